// File: rtl/dsp_macc_vec_p.sv
// Vector multiply-accumulate for fit scalar products: sum(coef*hit) plus a shifted
// intercept, with round-half-up and optional saturation of the final result.
module dsp_macc_vec_p #(
    parameter int AW       = 18,
    parameter int BW       = 16,
    parameter int CW       = 18,
    parameter int CSHIFT   = 18,
    parameter int ACCW     = 48,
    parameter int OUT_LSB  = 17,
    parameter int OUTW     = 15,
    parameter int TW       = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic            CLK_IN,
    input  logic            RST_IN,
    input  logic            CE_IN,
    input  logic            VALID_IN,
    input  logic            FIRST_IN,
    input  logic            LAST_IN,
    input  logic [AW-1:0]   A_IN,
    input  logic [BW-1:0]   B_IN,
    input  logic [CW-1:0]   C_IN,
    output logic            VALID_OUT,
    output logic [OUTW-1:0] P_OUT,
    output logic            OVERFLOW,
    output logic [TW-1:0]   TERMS_OUT,
    output logic            ERR_SEQ
);
    localparam int PW = AW + BW;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t state;

    logic                   s1_valid, s1_first, s1_last;
    logic signed [AW-1:0]   s1_a;
    logic signed [BW-1:0]   s1_b;
    logic signed [CW-1:0]   s1_c;

    logic                   s2_valid, s2_first, s2_last;
    logic signed [PW-1:0]   s2_prod;
    logic signed [CW-1:0]   s2_c;

    logic                   s3_done;
    logic signed [ACCW-1:0] s3_acc;
    logic [TW-1:0]          s3_terms;

    logic signed [ACCW-1:0] c_ext, prod_ext, acc_rnd, r_full;
    logic                   r_ovf;
    logic [OUTW-1:0]        r_out;

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state   <= IDLE;
            ERR_SEQ <= 1'b0;
        end else if (CE_IN) begin
            ERR_SEQ <= 1'b0;
            if (VALID_IN) begin
                case (state)
                    IDLE: begin
                        if (!FIRST_IN)
                            ERR_SEQ <= 1'b1;
                        else if (!LAST_IN)
                            state <= ACCUM;
                    end
                    ACCUM: begin
                        if (FIRST_IN)
                            ERR_SEQ <= 1'b1;
                        if (LAST_IN)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Beats without FIRST while idle are dropped here; a FIRST inside an open
    // vector simply restarts the accumulator downstream, so no result escapes.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
        end else if (CE_IN) begin
            s1_valid <= VALID_IN & (FIRST_IN | (state == ACCUM));
            s1_first <= FIRST_IN;
            s1_last  <= LAST_IN;
            s1_a     <= A_IN;
            s1_b     <= B_IN;
            s1_c     <= C_IN;
        end
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
            s2_c     <= '0;
        end else if (CE_IN) begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_prod  <= s1_a * s1_b;
            s2_c     <= s1_c;
        end
    end

    assign c_ext    = ACCW'(s2_c) <<< CSHIFT;
    assign prod_ext = ACCW'(s2_prod);

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            s3_done  <= 1'b0;
            s3_acc   <= '0;
            s3_terms <= '0;
        end else if (CE_IN) begin
            s3_done <= s2_valid & s2_last;
            if (s2_valid) begin
                if (s2_first) begin
                    s3_acc   <= c_ext + prod_ext;
                    s3_terms <= TW'(1);
                end else begin
                    s3_acc <= s3_acc + prod_ext;
                    if (s3_terms != {TW{1'b1}})
                        s3_terms <= s3_terms + TW'(1);
                end
            end
        end
    end

    // Overflow means the bits above the result's sign bit are not all copies of it.
    assign acc_rnd = s3_acc + (ACCW'(1) << (OUT_LSB - 1));
    assign r_full  = acc_rnd >>> OUT_LSB;
    assign r_ovf   = !((&r_full[ACCW-1:OUTW-1]) || !(|r_full[ACCW-1:OUTW-1]));

    always_comb begin
        r_out = r_full[OUTW-1:0];
        if (SATURATE && r_ovf)
            r_out = r_full[ACCW-1] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            VALID_OUT <= 1'b0;
            P_OUT     <= '0;
            OVERFLOW  <= 1'b0;
            TERMS_OUT <= '0;
        end else if (CE_IN) begin
            VALID_OUT <= s3_done;
            if (s3_done) begin
                P_OUT     <= r_out;
                OVERFLOW  <= r_ovf;
                TERMS_OUT <= s3_terms;
            end
        end
    end
endmodule

// File: tb/tb_dsp_macc_vec_p.sv
// Self-checking bench for dsp_macc_vec_p: directed cases followed by random beats,
// compared against a vector-level arithmetic model.
module tb_dsp_macc_vec_p;
    logic        clk, rst, ce, valid, first, last;
    logic [17:0] a_in;
    logic [15:0] b_in;
    logic [17:0] c_in;

    logic        vo_s, ovf_s, err_s;
    logic [14:0] p_s;
    logic [3:0]  terms_s;
    logic        vo_n, ovf_n, err_n;
    logic [14:0] p_n;
    logic [3:0]  terms_n;

    dsp_macc_vec_p #(.SATURATE(1'b1)) u_sat (
        .CLK_IN(clk), .RST_IN(rst), .CE_IN(ce), .VALID_IN(valid),
        .FIRST_IN(first), .LAST_IN(last), .A_IN(a_in), .B_IN(b_in), .C_IN(c_in),
        .VALID_OUT(vo_s), .P_OUT(p_s), .OVERFLOW(ovf_s), .TERMS_OUT(terms_s),
        .ERR_SEQ(err_s)
    );

    dsp_macc_vec_p #(.SATURATE(1'b0)) u_nosat (
        .CLK_IN(clk), .RST_IN(rst), .CE_IN(ce), .VALID_IN(valid),
        .FIRST_IN(first), .LAST_IN(last), .A_IN(a_in), .B_IN(b_in), .C_IN(c_in),
        .VALID_OUT(vo_n), .P_OUT(p_n), .OVERFLOW(ovf_n), .TERMS_OUT(terms_n),
        .ERR_SEQ(err_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint      due;
        logic [14:0] p;
        logic [14:0] pns;
        logic        ovf;
        logic [3:0]  terms;
    } res_t;

    res_t        pend[$];
    longint      ce_idx;
    longint      err_at;
    bit          in_vec;
    longint      vec_sum;
    int          vec_n;
    logic        exp_valid, exp_err, exp_ovf;
    logic [14:0] exp_p, exp_pns;
    logic [3:0]  exp_terms;
    int          check_cnt, pass_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h at ce_idx %0d", tag, obs, exp, ce_idx);
    endtask

    function automatic res_t makeResult(input longint sum, input int n, input longint due);
        res_t   res;
        longint r;
        r         = (sum + 65536) >>> 17;
        res.due   = due;
        res.ovf   = (r > 16383) || (r < -16384);
        res.pns   = r[14:0];
        res.p     = res.ovf ? ((r > 0) ? 15'h3FFF : 15'h4000) : r[14:0];
        res.terms = (n > 15) ? 4'd15 : 4'(n);
        return res;
    endfunction

    // Vector-level protocol: a beat lands on CE edge ce_idx+1, its error flag
    // shows after that edge and a closing LAST shows its result three edges later.
    task automatic modelBeat(input logic f, input logic l, input int a, input int b, input int c);
        longint edge_n;
        edge_n = ce_idx + 1;
        if (f) begin
            if (in_vec) err_at = edge_n;
            vec_sum = (longint'(c) <<< 18) + longint'(a) * longint'(b);
            vec_n   = 1;
            in_vec  = 1'b1;
        end else if (!in_vec) begin
            err_at = edge_n;
            return;
        end else begin
            vec_sum = vec_sum + longint'(a) * longint'(b);
            vec_n++;
        end
        if (l) begin
            pend.push_back(makeResult(vec_sum, vec_n, edge_n + 3));
            in_vec = 1'b0;
        end
    endtask

    task automatic checkOutput();
        check("valid_sat", 32'(vo_s), 32'(exp_valid));
        check("valid_nosat", 32'(vo_n), 32'(exp_valid));
        check("err_seq", 32'(err_s), 32'(exp_err));
        check("p_sat", 32'(p_s), 32'(exp_p));
        check("p_nosat", 32'(p_n), 32'(exp_pns));
        check("overflow", 32'(ovf_s), 32'(exp_ovf));
        check("terms", 32'(terms_s), 32'(exp_terms));
    endtask

    task automatic applyStimulus(input logic c_e, input logic v, input logic f, input logic l,
                                 input int a, input int b, input int c);
        res_t res;
        ce    = c_e;
        valid = v;
        first = f;
        last  = l;
        a_in  = 18'(a);
        b_in  = 16'(b);
        c_in  = 18'(c);
        if (c_e && v) modelBeat(f, l, a, b, c);
        @(posedge clk);
        #1;
        if (c_e) begin
            ce_idx++;
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == ce_idx) begin
                res       = pend.pop_front();
                exp_valid = 1'b1;
                exp_p     = res.p;
                exp_pns   = res.pns;
                exp_ovf   = res.ovf;
                exp_terms = res.terms;
            end
            exp_err = (err_at == ce_idx);
        end
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        pend.delete();
        in_vec    = 1'b0;
        err_at    = -1;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_p     = '0;
        exp_pns   = '0;
        exp_ovf   = 1'b0;
        exp_terms = '0;
        checkOutput();
        check("reset_valid_nosat", 32'(vo_n), 32'd0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int a, b, c;
        logic f, l, v, e;
        check_cnt = 0;
        pass_cnt  = 0;
        ce_idx    = 0;
        vec_sum   = 0;
        vec_n     = 0;
        ce = 1'b0; valid = 1'b0; first = 1'b0; last = 1'b0;
        a_in = '0; b_in = '0; c_in = '0;
        rst = 1'b0;
        #1;
        doReset();
        idle(2);

        $display("[TB] single term and rounding");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2, 3, 1);
        idle(4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 256, 256, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, -256, 256, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1000, 1000, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 0, 5, 0);
        idle(4);

        $display("[TB] overflow and saturation");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 131071);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, -131072);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 131071, -32768, 0);
        idle(4);

        $display("[TB] back-to-back with enable gaps");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 7, 9000, 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, -5, 20000, -2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 99, 99, 99);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 99, 99, 99);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 300, 300, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        idle(4);

        $display("[TB] protocol errors");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 50, 50, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 500, 500, 4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 700, 200, -3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 11, 13, 0);
        idle(5);

        $display("[TB] term counter saturation");
        for (int i = 0; i < 17; i++)
            applyStimulus(1'b1, 1'b1, (i == 0), (i == 16), i * 37 - 200, 1500 - i * 90, 5);
        idle(5);

        $display("[TB] reset mid-vector");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1234, 4321, 77);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 999, 888, 0);
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5, 5, 0);
        idle(4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 400, 600, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, -300, 100, 0);
        idle(5);

        $display("[TB] random beats");
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                a = int'($urandom_range(0, 600)) - 300;
                b = int'($urandom_range(0, 600)) - 300;
                c = int'($urandom_range(0, 40)) - 20;
            end else begin
                a = int'($urandom_range(0, 262143)) - 131072;
                b = int'($urandom_range(0, 65535)) - 32768;
                c = int'($urandom_range(0, 262143)) - 131072;
            end
            applyStimulus(e, v, f, l, a, b, c);
            if ($urandom_range(0, 199) == 0) doReset();
        end
        idle(6);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
